rv32i_core: RTL and testbench

- Single-cycle RV32I integer core (RV32I base, no CSRs, interrupts or exceptions).
- Fetch is external: the core drives pc_out, the environment returns the instruction word on inst in the same cycle.
- Data memory is external and asynchronous-read: the core drives address, store data, write enable and access type; load data returns combinationally on mem_data.
- Sits under the simulation top, which watches inst for EBREAK (0x00100073) to end simulation.

---
 rtl/rv32i_pkg.sv | 65 ++++++
 rtl/rv32i_regfile.sv | 34 +++
 rtl/rv32i_core.sv | 214 +++++++++++++++++++++
 tb/tb_rv32i_core.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the single-cycle RV32I core.
//   - Base opcode constants
//   - ALU operation, writeback-source and next-PC-source enums
//   - Default reset PC and the funct3/alt -> ALU op decode helper
package rv32i_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [3:0] {
        AluAdd,
        AluSub,
        AluSll,
        AluSlt,
        AluSltu,
        AluXor,
        AluSrl,
        AluSra,
        AluOr,
        AluAnd
    } alu_op_e;

    typedef enum logic [2:0] {
        WbNone,
        WbAlu,
        WbImm,
        WbPcImm,
        WbPc4,
        WbMem
    } wb_sel_e;

    typedef enum logic [1:0] {
        NpcPc4,
        NpcJal,
        NpcJalr,
        NpcBranch
    } npc_sel_e;

    // alt selects SUB (funct3 000) or SRA (funct3 101); ignored for the rest.
    function automatic alu_op_e alu_op_decode(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        unique case (funct3)
            3'b000:  op = alt ? AluSub : AluAdd;
            3'b001:  op = AluSll;
            3'b010:  op = AluSlt;
            3'b011:  op = AluSltu;
            3'b100:  op = AluXor;
            3'b101:  op = alt ? AluSra : AluSrl;
            3'b110:  op = AluOr;
            default: op = AluAnd;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_regfile.sv
// 32 x 32-bit integer register file.
//   clk, rst          : clock, asynchronous active-low reset (clears x1..x31)
//   raddr_a/raddr_b   : combinational read addresses; rdata_a/rdata_b the values
//   we, waddr, wdata  : synchronous write port; writes to x0 are dropped
// A read of the register being written on the same edge sees the old value.
module rv32i_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr_a,
    input  logic [4:0]  raddr_b,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b
);

    // x0 has no storage; it is hard-wired to zero on the read side.
    logic [31:0] regs [1:31];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= 32'h0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? 32'h0 : regs[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? 32'h0 : regs[raddr_b];

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I integer core: one instruction retires per rising clk.
//   clk, rst  : clock, asynchronous active-low reset (PC <- RESET_PC, GPRs <- 0)
//   inst      : instruction word at pc_out, valid in the same cycle
//   mem_data  : load data, already extended by memory, combinational from mem_addr/memop
//   memop     : funct3 of the load/store, 000 for any other instruction
//   memdata   : store data (rs2, unshifted)
//   mem_wen   : high for the whole cycle of a store
//   mem_addr  : ALU result (rs1 + imm for loads/stores)
//   pc_out    : current PC
//   result    : ALU result of the current instruction
// Unknown opcodes, FENCE and SYSTEM instructions retire as NOPs.
module rv32i_core
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic [31:0] mem_data,
    output logic [2:0]  memop,
    output logic [31:0] memdata,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] pc_out,
    output logic [31:0] result
);

    logic [31:0] pc_q, pc_d;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;

    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm;
    logic [31:0] rs1_val, rs2_val;
    logic [31:0] op_a, op_b;
    logic [31:0] alu_out;
    logic [31:0] pc_plus4, pc_imm;
    logic [31:0] wb_data;
    logic        rf_we;
    logic        is_mem;
    logic        is_store;
    logic        branch_taken;

    alu_op_e  alu_op;
    wb_sel_e  wb_sel;
    npc_sel_e npc_sel;

    assign opcode = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];

    assign imm_i = {{20{inst[31]}}, inst[31:20]};
    assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u = {inst[31:12], 12'h000};
    assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    rv32i_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rs1),
        .raddr_b (rs2),
        .we      (rf_we),
        .waddr   (rd),
        .wdata   (wb_data),
        .rdata_a (rs1_val),
        .rdata_b (rs2_val)
    );

    // Decode: operand selection, ALU op, writeback and next-PC source.
    always_comb begin
        imm      = imm_i;
        op_a     = rs1_val;
        op_b     = imm_i;
        alu_op   = AluAdd;
        wb_sel   = WbNone;
        npc_sel  = NpcPc4;
        is_mem   = 1'b0;
        is_store = 1'b0;

        case (opcode)
            OPC_LUI: begin
                imm    = imm_u;
                op_a   = 32'h0;
                op_b   = imm_u;
                wb_sel = WbImm;
            end
            OPC_AUIPC: begin
                imm    = imm_u;
                op_a   = pc_q;
                op_b   = imm_u;
                wb_sel = WbPcImm;
            end
            OPC_JAL: begin
                imm     = imm_j;
                op_a    = pc_q;
                op_b    = imm_j;
                wb_sel  = WbPc4;
                npc_sel = NpcJal;
            end
            OPC_JALR: begin
                wb_sel  = WbPc4;
                npc_sel = NpcJalr;
            end
            OPC_BRANCH: begin
                imm     = imm_b;
                op_b    = rs2_val;
                alu_op  = AluSub;
                npc_sel = NpcBranch;
            end
            OPC_LOAD: begin
                wb_sel = WbMem;
                is_mem = 1'b1;
            end
            OPC_STORE: begin
                imm      = imm_s;
                op_b     = imm_s;
                is_mem   = 1'b1;
                is_store = 1'b1;
            end
            OPC_OPIMM: begin
                // inst[30] is an immediate bit for ADDI, so it only means SRA here.
                alu_op = alu_op_decode(funct3, inst[30] && (funct3 == 3'b101));
                wb_sel = WbAlu;
            end
            OPC_OP: begin
                op_b   = rs2_val;
                alu_op = alu_op_decode(funct3, inst[30]);
                wb_sel = WbAlu;
            end
            default: begin
                // FENCE, SYSTEM and unknown opcodes: no side effects.
            end
        endcase
    end

    always_comb begin
        alu_out = 32'h0;
        unique case (alu_op)
            AluAdd:  alu_out = op_a + op_b;
            AluSub:  alu_out = op_a - op_b;
            AluSll:  alu_out = op_a << op_b[4:0];
            AluSlt:  alu_out = {31'h0, $signed(op_a) < $signed(op_b)};
            AluSltu: alu_out = {31'h0, op_a < op_b};
            AluXor:  alu_out = op_a ^ op_b;
            AluSrl:  alu_out = op_a >> op_b[4:0];
            AluSra:  alu_out = $unsigned($signed(op_a) >>> op_b[4:0]);
            AluOr:   alu_out = op_a | op_b;
            AluAnd:  alu_out = op_a & op_b;
            default: alu_out = 32'h0;
        endcase
    end

    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'b000:  branch_taken = (rs1_val == rs2_val);
            3'b001:  branch_taken = (rs1_val != rs2_val);
            3'b100:  branch_taken = ($signed(rs1_val) < $signed(rs2_val));
            3'b101:  branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'b110:  branch_taken = (rs1_val < rs2_val);
            3'b111:  branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    assign pc_plus4 = pc_q + 32'd4;
    assign pc_imm   = pc_q + imm;

    always_comb begin
        pc_d = pc_plus4;
        unique case (npc_sel)
            NpcPc4:    pc_d = pc_plus4;
            NpcJal:    pc_d = pc_imm;
            NpcJalr:   pc_d = alu_out & ~32'h1;
            NpcBranch: pc_d = branch_taken ? pc_imm : pc_plus4;
            default:   pc_d = pc_plus4;
        endcase
    end

    always_comb begin
        wb_data = alu_out;
        case (wb_sel)
            WbImm:   wb_data = imm;
            WbPcImm: wb_data = pc_imm;
            WbPc4:   wb_data = pc_plus4;
            WbMem:   wb_data = mem_data;
            default: wb_data = alu_out;
        endcase
    end

    assign rf_we = (wb_sel != WbNone);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_out   = pc_q;
    assign result   = alu_out;
    assign mem_addr = alu_out;
    assign memdata  = rs2_val;
    assign mem_wen  = is_store;
    assign memop    = is_mem ? funct3 : 3'b000;

endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: directed vector table, then random instructions
// checked against an instruction-level reference model.
module tb_rv32i_core;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] inst;
    logic [31:0] mem_data;
    logic [2:0]  memop;
    logic [31:0] memdata;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] pc_out;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    rv32i_core #(.RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .rst      (rst),
        .inst     (inst),
        .mem_data (mem_data),
        .memop    (memop),
        .memdata  (memdata),
        .mem_wen  (mem_wen),
        .mem_addr (mem_addr),
        .pc_out   (pc_out),
        .result   (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction
    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rd, op};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
    endfunction

    // ---------------- reset ----------------
    task automatic do_reset();
        @(negedge clk);
        inst     = NOP;
        mem_data = 32'h0;
        #2 rst = 1'b0;
        #1 chk("reset_pc_async", pc_out, RST_PC);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_pc_held", pc_out, RST_PC);
        rst = 1'b1;
        #1 chk("reset_pc_release", pc_out, RST_PC);
        @(posedge clk);
        #1 chk("reset_pc_after_nop", pc_out, RST_PC + 32'd4);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic        rst_before;
        logic [31:0] inst;
        logic [31:0] mdata;
        logic [31:0] exp_pc;
        logic        chk_res;
        logic [31:0] exp_res;
        logic        exp_wen;
        logic [2:0]  exp_op;
        logic        chk_mem;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rb, input logic [31:0] i, input logic [31:0] md,
                                input logic [31:0] pc, input logic cr, input logic [31:0] r,
                                input logic w, input logic [2:0] op, input logic cm,
                                input logic [31:0] a, input logic [31:0] wd);
        vec_t v;
        v.rst_before = rb; v.inst = i; v.mdata = md; v.exp_pc = pc;
        v.chk_res = cr; v.exp_res = r; v.exp_wen = w; v.exp_op = op;
        v.chk_mem = cm; v.exp_addr = a; v.exp_wdata = wd;
        return v;
    endfunction

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b, input logic alt);
        int unsigned sh;
        sh = b % 32;
        case (f3)
            3'd0:    return alt ? a - b : a + b;
            3'd1:    return a << sh;
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return alt ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic logic ref_branch(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
        case (f3)
            3'd0:    return a == b;
            3'd1:    return a != b;
            3'd4:    return $signed(a) < $signed(b);
            3'd5:    return $signed(a) >= $signed(b);
            3'd6:    return a < b;
            3'd7:    return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_pc = RST_PC + 32'd4;
    endtask

    // Apply one instruction, compare DUT against the model, then retire it in both.
    task automatic exec_rand(input logic [31:0] i, input logic [31:0] md, input string tag);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] a, b, imm_i, imm_s, imm_b, imm_j, imm_u;
        logic [31:0] npc, rdv, e_res, e_addr;
        logic        wr, e_wen, c_res, c_addr;
        logic [2:0]  e_op;
        logic [12:0] b13;
        logic [20:0] j21;
        opc = i[6:0]; f3 = i[14:12]; rd = i[11:7];
        a = m_regs[i[19:15]]; b = m_regs[i[24:20]];
        imm_i = 32'($signed(i[31:20]));
        imm_s = 32'($signed({i[31:25], i[11:7]}));
        b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        imm_b = 32'($signed(b13));
        j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        imm_j = 32'($signed(j21));
        imm_u = {i[31:12], 12'h000};
        npc = m_pc + 32'd4; rdv = 32'h0; wr = 1'b0;
        e_wen = 1'b0; e_op = 3'd0; e_res = 32'h0; e_addr = 32'h0;
        c_res = 1'b0; c_addr = 1'b0;
        case (opc)
            7'h37: begin rdv = imm_u; wr = 1'b1; end
            7'h17: begin rdv = m_pc + imm_u; wr = 1'b1; end
            7'h6f: begin rdv = m_pc + 32'd4; wr = 1'b1; npc = m_pc + imm_j; end
            7'h67: begin rdv = m_pc + 32'd4; wr = 1'b1; npc = (a + imm_i) & ~32'h1; end
            7'h63: if (ref_branch(f3, a, b)) npc = m_pc + imm_b;
            7'h03: begin
                e_addr = a + imm_i; c_addr = 1'b1; e_op = f3; rdv = md; wr = 1'b1;
            end
            7'h23: begin
                e_addr = a + imm_s; c_addr = 1'b1; e_op = f3; e_wen = 1'b1;
            end
            7'h13: begin
                e_res = ref_alu(f3, a, imm_i, (f3 == 3'd5) && i[30]);
                c_res = 1'b1; rdv = e_res; wr = 1'b1;
            end
            7'h33: begin
                e_res = ref_alu(f3, a, b, i[30]); c_res = 1'b1; rdv = e_res; wr = 1'b1;
            end
            default: ;
        endcase
        inst = i;
        mem_data = md;
        @(negedge clk);
        chk({tag, "_pc"}, pc_out, m_pc);
        chk({tag, "_wen"}, {31'h0, mem_wen}, {31'h0, e_wen});
        chk({tag, "_memop"}, {29'h0, memop}, {29'h0, e_op});
        if (c_res) chk({tag, "_result"}, result, e_res);
        if (c_addr) chk({tag, "_addr"}, mem_addr, e_addr);
        if (e_wen) chk({tag, "_wdata"}, memdata, b);
        @(posedge clk);
        #1;
        if (wr && rd != 5'd0) m_regs[rd] = rdv;
        m_pc = npc;
    endtask

    // Reads every GPR through ADD x0,xr,x0 (no write-back).
    task automatic sweep(input string tag);
        for (int r = 1; r < 32; r++) begin
            exec_rand(enc_r(7'h00, 5'd0, 5'(r), 3'd0, 5'd0), 32'h0, $sformatf("%s_x%0d", tag, r));
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] u;
        logic [2:0]  f3;
        logic [4:0]  rd, rs1, rs2;
        logic [12:0] b13;
        logic [20:0] j21;
        int cls;
        logic [2:0] ld_f3 [5];
        logic [2:0] br_f3 [6];
        ld_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        br_f3 = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        u = $urandom;
        rd = 5'($urandom % 16); rs1 = 5'($urandom % 16); rs2 = 5'($urandom % 16);
        f3 = 3'($urandom % 8);
        cls = $urandom % 12;
        case (cls)
            0, 1: return enc_i(u[11:0], rs1, f3, rd, 7'h13);
            2, 3: return enc_r(u[0] ? 7'h20 : 7'h00, rs2, rs1, f3, rd);
            4:    return enc_u(u[19:0], rd, 7'h37);
            5:    return enc_u(u[19:0], rd, 7'h17);
            6:    return enc_i(u[11:0], rs1, ld_f3[$urandom % 5], rd, 7'h03);
            7:    return enc_s(u[11:0], rs2, rs1, 3'($urandom % 3));
            8: begin
                b13 = {u[12:1], 1'b0};
                return enc_b(b13, rs2, rs1, br_f3[$urandom % 6]);
            end
            9: begin
                j21 = {u[20:1], 1'b0};
                return enc_j(j21, rd);
            end
            10:   return enc_i(u[11:0], rs1, 3'd0, rd, 7'h67);
            default: begin
                case ($urandom % 4)
                    0: return 32'h0000_000F;
                    1: return 32'h0000_0073;
                    2: return 32'h0010_0073;
                    default: return {u[31:7], 7'h7F};
                endcase
            end
        endcase
    endfunction

    initial begin
        rst = 1'b0;
        inst = NOP;
        mem_data = 32'h0;

        // ALU, x0, store and load sequence (first instruction at RST_PC+4)
        vecs.push_back(mk(1, 32'hFFF0_0093, 0, 32'h8000_0004, 1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_i(12'h004, 5'd1, 3'd5, 5'd2, 7'h13), 0, 32'h8000_0008,
                          1, 32'h0FFF_FFFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_i(12'h404, 5'd1, 3'd5, 5'd3, 7'h13), 0, 32'h8000_000C,
                          1, 32'hFFFF_FFFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_r(7'h20, 5'd1, 5'd0, 3'd0, 5'd4), 0, 32'h8000_0010,
                          1, 32'h0000_0001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_r(7'h00, 5'd0, 5'd2, 3'd0, 5'd6), 0, 32'h8000_0014,
                          1, 32'h0FFF_FFFF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13), 0, 32'h8000_0018,
                          1, 32'h0000_0005, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd5), 0, 32'h8000_001C,
                          1, 32'h0000_0000, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_u(20'h80000, 5'd1, 7'h37), 0, 32'h8000_0020,
                          0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_i(12'h100, 5'd1, 3'd0, 5'd1, 7'h13), 0, 32'h8000_0024,
                          1, 32'h8000_0100, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_u(20'h12345, 5'd2, 7'h37), 0, 32'h8000_0028,
                          0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_i(12'h678, 5'd2, 3'd0, 5'd2, 7'h13), 0, 32'h8000_002C,
                          1, 32'h1234_5678, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_s(12'd8, 5'd2, 5'd1, 3'd2), 0, 32'h8000_0030,
                          0, 0, 1, 3'b010, 1, 32'h8000_0108, 32'h1234_5678));
        vecs.push_back(mk(0, enc_i(12'd0, 5'd1, 3'd4, 5'd3, 7'h03), 32'h0000_0078, 32'h8000_0034,
                          0, 0, 0, 3'b100, 1, 32'h8000_0100, 32'h0));
        vecs.push_back(mk(0, enc_r(7'h00, 5'd0, 5'd3, 3'd0, 5'd4), 0, 32'h8000_0038,
                          1, 32'h0000_0078, 0, 0, 1, 32'h0000_0078, 32'h0));
        // Control flow after a fresh reset
        vecs.push_back(mk(1, NOP, 0, 32'h8000_0004, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 32'h8000_0008, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 32'h8000_000C, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_b(13'h1FF8, 5'd0, 5'd0, 3'd0), 0, 32'h8000_0010,
                          0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_b(13'h1FF8, 5'd0, 5'd0, 3'd1), 0, 32'h8000_0008,
                          0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_j(21'd20, 5'd0), 0, 32'h8000_000C, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_j(21'd16, 5'd1), 0, 32'h8000_0020, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_i(12'd1, 5'd1, 3'd0, 5'd0, 7'h67), 0, 32'h8000_0030,
                          0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, enc_r(7'h00, 5'd0, 5'd1, 3'd0, 5'd0), 0, 32'h8000_0024,
                          1, 32'h8000_0024, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, NOP, 0, 32'h8000_0028, 0, 0, 0, 0, 0, 0, 0));

        foreach (vecs[k]) begin
            if (vecs[k].rst_before) do_reset();
            inst = vecs[k].inst;
            mem_data = vecs[k].mdata;
            @(negedge clk);
            chk($sformatf("v%0d_pc", k), pc_out, vecs[k].exp_pc);
            chk($sformatf("v%0d_wen", k), {31'h0, mem_wen}, {31'h0, vecs[k].exp_wen});
            chk($sformatf("v%0d_memop", k), {29'h0, memop}, {29'h0, vecs[k].exp_op});
            if (vecs[k].chk_res) chk($sformatf("v%0d_result", k), result, vecs[k].exp_res);
            if (vecs[k].chk_mem) begin
                chk($sformatf("v%0d_addr", k), mem_addr, vecs[k].exp_addr);
                chk($sformatf("v%0d_wdata", k), memdata, vecs[k].exp_wdata);
            end
            @(posedge clk);
            #1;
        end

        // Random instruction stream against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 1500; n++) begin
            exec_rand(rand_inst(), $urandom, $sformatf("r%0d", n));
            if (n == 700) begin
                sweep("pre_rst");
                do_reset();
                model_reset();
                sweep("post_rst");
            end
        end
        sweep("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
